// File: rtl/uart_pkg.sv
// Shared definitions for the UART line-echo slice: echo FSM states and ASCII control bytes.
package uart_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    EMIT_CR,
    EMIT_LF
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;

endpackage

// File: rtl/uart_line_echo_if.sv
// Byte streams around the line echo: RX byte + ready level in, TX valid/ready byte stream out.
interface uart_line_echo_if;

  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data,
    input  rx_ready,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output rx_data,
    output rx_ready,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

endinterface

// File: rtl/line_ram.sv
// Line buffer storage: simple dual-port RAM, one write and one registered read port, single clock.
module line_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_line_echo.sv
// Collects received bytes into a line and replays it, followed by CR LF, on EOL or when full.
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int unsigned LINE_MAX = 16,
  parameter logic [7:0]  EOL_CHAR = CR,
  parameter logic [7:0]  BS_CHAR  = BS
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_line_echo_if.master             bus,
  output logic [$clog2(LINE_MAX+1)-1:0] line_len,
  output logic                         overflow,
  output logic                         busy
);

  localparam int unsigned LW = $clog2(LINE_MAX + 1);
  localparam int unsigned AW = $clog2(LINE_MAX);

  state_e        state_q,    state_d;
  logic [LW-1:0] line_len_q, line_len_d;
  logic [LW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [7:0]    tx_byte_q,  tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q,     busy_d;
  logic          overflow_q, overflow_d;
  logic          rx_prev_q,  rx_prev_d;

  logic          rx_take;
  logic          tx_accept;
  logic          wr_en;
  logic [7:0]    ram_rd_data;

  assign rx_take   = bus.rx_ready & ~rx_prev_q;
  assign tx_accept = tx_valid_q & bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    line_len_d = line_len_q;
    rd_ptr_d   = rd_ptr_q;
    tx_byte_d  = tx_byte_q;
    overflow_d = overflow_q;
    rx_prev_d  = bus.rx_ready;
    wr_en      = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (rx_take) begin
          if (bus.rx_data == EOL_CHAR) begin
            rd_ptr_d = '0;
            if (line_len_q != '0) begin
              state_d = EMIT;
            end else begin
              state_d   = EMIT_CR;
              tx_byte_d = CR;
            end
          end else if (bus.rx_data == BS_CHAR) begin
            if (line_len_q != '0) begin
              line_len_d = line_len_q - LW'(1);
            end
          end else begin
            wr_en      = 1'b1;
            line_len_d = line_len_q + LW'(1);
            if (line_len_d == LW'(LINE_MAX)) begin
              overflow_d = 1'b1;
              rd_ptr_d   = '0;
              state_d    = EMIT;
            end
          end
        end
      end

      // The RAM read address follows rd_ptr_d, so the byte for the next cycle is
      // already registered when the pointer advances on an accept.
      EMIT: begin
        if (tx_accept) begin
          if (rd_ptr_q + LW'(1) == line_len_q) begin
            state_d   = EMIT_CR;
            tx_byte_d = CR;
          end else begin
            rd_ptr_d = rd_ptr_q + LW'(1);
          end
        end
      end

      EMIT_CR: begin
        if (tx_accept) begin
          state_d   = EMIT_LF;
          tx_byte_d = LF;
        end
      end

      EMIT_LF: begin
        if (tx_accept) begin
          state_d    = COLLECT;
          line_len_d = '0;
          rd_ptr_d   = '0;
          tx_byte_d  = '0;
        end
      end

      default: state_d = COLLECT;
    endcase

    tx_valid_d = (state_d != COLLECT);
    busy_d     = (state_d != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      line_len_q <= '0;
      rd_ptr_q   <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      line_len_q <= line_len_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  line_ram #(
    .DEPTH(LINE_MAX)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (line_len_q[AW-1:0]),
    .wr_data (bus.rx_data),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  assign bus.tx_data  = (state_q == EMIT) ? ram_rd_data : tx_byte_q;
  assign bus.tx_valid = tx_valid_q;
  assign line_len     = line_len_q;
  assign overflow     = overflow_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// Scoreboard bench for uart_line_echo: a line model predicts the TX stream, a monitor pops and compares.
module tb_uart_line_echo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] line_len;
  logic       overflow;
  logic       busy;

  uart_line_echo_if bus ();

  uart_line_echo #(
    .LINE_MAX (16),
    .EOL_CHAR (8'h0D),
    .BS_CHAR  (8'h08)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .line_len (line_len),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q [$];
  logic [7:0] line_m [$];
  logic       ovf_m = 1'b0;

  // Independent model of the line buffer; pushes the expected echo on EOL or full line.
  task automatic model_rx(input logic [7:0] b);
    if (b == 8'h0D) begin
      foreach (line_m[i]) exp_q.push_back(line_m[i]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      line_m.delete();
    end else if (b == 8'h08) begin
      if (line_m.size() > 0) void'(line_m.pop_back());
    end else begin
      line_m.push_back(b);
      if (line_m.size() == 16) begin
        foreach (line_m[i]) exp_q.push_back(line_m[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        line_m.delete();
        ovf_m = 1'b1;
      end
    end
  endtask

  // Monitor: inputs change only at posedge+1, so negedge values are what the next edge sees.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)
          $display("FAIL tx_hold got valid=%0b data=%02h exp valid=1 data=%02h", bus.tx_valid, bus.tx_data, prev_data);
        else passed++;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL tx_unexpected got %02h exp none", bus.tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.tx_data !== e) $display("FAIL tx_byte got %02h exp %02h", bus.tx_data, e);
          else passed++;
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    model_rx(b);
    tick();
    bus.rx_ready = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (!busy && !bus.tx_valid && exp_q.size() == 0) done = 1;
      else tick();
    end
    checks++;
    if (!done) $display("FAIL idle_timeout got busy=%0b pending=%0d exp idle", busy, exp_q.size());
    else passed++;
  endtask

  task automatic check_len(input string name, input int exp_len);
    checks++;
    if (line_len !== 5'(exp_len)) $display("FAIL %s got line_len=%0d exp %0d", name, line_len, exp_len);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data  = 8'h55;
    bus.rx_ready = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs got valid=%0b data=%02h ovf=%0b busy=%0b exp all 0", bus.tx_valid, bus.tx_data, overflow, busy);
    else passed++;
    check_len("reset_len", 0);
    repeat (4) tick();
    check_len("reset_level_not_taken", 0);
    bus.rx_ready = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    send_byte(8'h41);
    check_len("basic_len1", 1);
    send_byte(8'h42);
    check_len("basic_len2", 2);
    bus.rx_data  = 8'h0D;
    bus.rx_ready = 1'b1;
    model_rx(8'h0D);
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41)
      $display("FAIL eol_latency got valid=%0b data=%02h exp valid=1 data=41", bus.tx_valid, bus.tx_data);
    else passed++;
    bus.rx_ready = 1'b0;
    wait_idle(50);
    check_len("basic_len_after", 0);
    checks++;
    if (overflow !== 1'b0) $display("FAIL basic_ovf got %0b exp 0", overflow);
    else passed++;
  endtask

  task automatic test_backspace();
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    send_byte(8'h08);
    check_len("bs_len", 2);
    send_byte(8'h44);
    check_len("bs_len_after_d", line_m.size());
    send_byte(8'h0D);
    wait_idle(50);
    send_byte(8'h08);
    check_len("bs_empty", 0);
    checks++;
    if (busy !== 1'b0) $display("FAIL bs_empty_busy got %0b exp 0", busy);
    else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set got %0b exp 1", overflow);
    else passed++;
    wait_idle(80);
    send_byte(8'h61);
    send_byte(8'h0D);
    wait_idle(50);
    checks++;
    if (overflow !== ovf_m) $display("FAIL ovf_sticky got %0b exp %0b", overflow, ovf_m);
    else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] msg [5] = '{8'h53, 8'h54, 8'h41, 8'h4C, 8'h4C};
    bus.tx_ready = 1'b0;
    foreach (msg[i]) send_byte(msg[i]);
    send_byte(8'h0D);
    for (int i = 0; i < 300; i++) begin
      bus.tx_ready = (i % 3 == 0);
      tick();
      if (!busy && exp_q.size() == 0) break;
    end
    bus.tx_ready = 1'b1;
    wait_idle(20);
  endtask

  task automatic test_hold();
    bus.rx_data  = 8'h58;
    bus.rx_ready = 1'b1;
    model_rx(8'h58);
    repeat (50) tick();
    bus.rx_ready = 1'b0;
    tick();
    check_len("hold_one_take", 1);
    bus.tx_ready = 1'b0;
    send_byte(8'h0D);
    bus.rx_data  = 8'h5A;
    bus.rx_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL hold_busy got %0b exp 1", busy);
    else passed++;
    bus.tx_ready = 1'b1;
    wait_idle(50);
    repeat (3) tick();
    check_len("z_dropped", 0);
    bus.rx_ready = 1'b0;
    tick();
    send_byte(8'h0D);
    wait_idle(30);
    check_len("empty_line_len", 0);
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    send_byte(8'h4D);
    send_byte(8'h4E);
    send_byte(8'h4F);
    send_byte(8'h50);
    send_byte(8'h0D);
    bus.tx_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    tick();
    checks++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid got valid=%0b busy=%0b exp 0 0", bus.tx_valid, busy);
    else passed++;
    check_len("reset_mid_len", 0);
    rst = 1'b0;
    exp_q.delete();
    line_m.delete();
    ovf_m = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    send_byte(8'h51);
    send_byte(8'h0D);
    wait_idle(50);
    checks++;
    if (overflow !== 1'b0) $display("FAIL reset_mid_ovf got %0b exp 0", overflow);
    else passed++;
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_ready = 1'b0;
    bus.tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_backspace();
    test_overflow();
    test_stall();
    test_hold();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
